// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: registered occupancy and threshold flags,
// sticky overflow/underflow, and a standard or first-word-fall-through read port.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             wa;
    logic             ra;

    assign wa = wr_en && !full;
    assign ra = rd_en && !empty;

    always_comb begin
        count_nxt = count;
        if (wa && !ra)
            count_nxt = count + ONE;
        else if (ra && !wa)
            count_nxt = count - ONE;
    end

    // Flags are derived from the next count so they always agree with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_C == '0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wa)
                wr_ptr <= wr_ptr + ONE;
            if (ra)
                rd_ptr <= rd_ptr + ONE;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            if (wr_en && full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (rd_en && empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wa && !rst)
            mem[wr_ptr[AW-1:0]] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr[AW-1:0]];
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst)
                    data_out <= '0;
                else if (ra)
                    data_out <= mem[rd_ptr[AW-1:0]];
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read 8x8 instance and a FWFT 16x32
// instance, each checked every cycle against a queue model plus literal points.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_wr = 0, a_rd = 0, a_clr = 0, a_rst = 0;
    logic [7:0]  a_din = '0;
    logic [7:0]  a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_ov, a_uf;
    logic [3:0]  a_cnt;

    logic        b_wr = 0, b_rd = 0, b_clr = 0, b_rst = 0;
    logic [31:0] b_din = '0;
    logic [31:0] b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_ov, b_uf;
    logic [4:0]  b_cnt;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(0)) dut_a (
        .clk(clk), .rst(a_rst), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
        .clr_err(a_clr), .data_out(a_dout), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
        .overflow(a_ov), .underflow(a_uf)
    );

    sync_fifo_param #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3), .FWFT(1)) dut_b (
        .clk(clk), .rst(b_rst), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
        .clr_err(b_clr), .data_out(b_dout), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
        .overflow(b_ov), .underflow(b_uf)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    logic [7:0]  qa[$];
    logic        ma_ov = 0, ma_uf = 0;
    logic [7:0]  ma_dout = '0;
    logic [31:0] qb[$];
    logic        mb_ov = 0, mb_uf = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_a(input logic wr, input logic [7:0] din, input logic rd,
                           input logic clr, input logic rs);
        bit pf, pe;
        if (rs) begin
            qa.delete();
            ma_ov = 0; ma_uf = 0; ma_dout = '0;
            return;
        end
        pf = (qa.size() == 8);
        pe = (qa.size() == 0);
        if (rd && !pe) ma_dout = qa.pop_front();
        if (wr && !pf) qa.push_back(din);
        if (wr && pf) ma_ov = 1; else if (clr) ma_ov = 0;
        if (rd && pe) ma_uf = 1; else if (clr) ma_uf = 0;
    endtask

    task automatic model_b(input logic wr, input logic [31:0] din, input logic rd,
                           input logic clr, input logic rs);
        bit pf, pe;
        logic [31:0] dummy;
        if (rs) begin
            qb.delete();
            mb_ov = 0; mb_uf = 0;
            return;
        end
        pf = (qb.size() == 16);
        pe = (qb.size() == 0);
        if (rd && !pe) dummy = qb.pop_front();
        if (wr && !pf) qb.push_back(din);
        if (wr && pf) mb_ov = 1; else if (clr) mb_ov = 0;
        if (rd && pe) mb_uf = 1; else if (clr) mb_uf = 0;
    endtask

    task automatic step_a(input logic wr, input logic [7:0] din, input logic rd,
                          input logic clr, input logic rs);
        @(negedge clk);
        a_wr = wr; a_din = din; a_rd = rd; a_clr = clr; a_rst = rs;
        @(posedge clk);
        model_a(wr, din, rd, clr, rs);
        #1;
        a_wr = 0; a_rd = 0; a_clr = 0; a_rst = 0;
    endtask

    task automatic step_b(input logic wr, input logic [31:0] din, input logic rd,
                          input logic clr, input logic rs);
        @(negedge clk);
        b_wr = wr; b_din = din; b_rd = rd; b_clr = clr; b_rst = rs;
        @(posedge clk);
        model_b(wr, din, rd, clr, rs);
        #1;
        b_wr = 0; b_rd = 0; b_clr = 0; b_rst = 0;
    endtask

    // Model-vs-DUT comparison on every falling edge once both DUTs are reset.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_count", 32'(a_cnt), 32'(qa.size()));
            chk("a_full",  32'(a_full),  32'(qa.size() == 8));
            chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
            chk("a_af",    32'(a_af),    32'(qa.size() >= 7));
            chk("a_ae",    32'(a_ae),    32'(qa.size() <= 1));
            chk("a_ov",    32'(a_ov),    32'(ma_ov));
            chk("a_uf",    32'(a_uf),    32'(ma_uf));
            chk("a_dout",  32'(a_dout),  32'(ma_dout));
            chk("b_count", 32'(b_cnt), 32'(qb.size()));
            chk("b_full",  32'(b_full),  32'(qb.size() == 16));
            chk("b_empty", 32'(b_empty), 32'(qb.size() == 0));
            chk("b_af",    32'(b_af),    32'(qb.size() >= 12));
            chk("b_ae",    32'(b_ae),    32'(qb.size() <= 3));
            chk("b_ov",    32'(b_ov),    32'(mb_ov));
            chk("b_uf",    32'(b_uf),    32'(mb_uf));
            if (qb.size() != 0)
                chk("b_dout", b_dout, qb[0]);
        end
    end

    initial begin
        step_a(0, 8'h00, 0, 0, 1);
        step_b(0, 32'h0, 0, 0, 1);
        chk_on = 1;
        chk("lit_a_rst_count", 32'(a_cnt), 32'd0);
        chk("lit_a_rst_empty", 32'(a_empty), 32'd1);
        chk("lit_a_rst_full",  32'(a_full), 32'd0);
        chk("lit_a_rst_ae",    32'(a_ae), 32'd1);
        chk("lit_a_rst_dout",  32'(a_dout), 32'd0);

        // Fill 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            step_a(1, 8'(8'h10 + i), 0, 0, 0);
            if (i == 5) chk("lit_a_af_at6", 32'(a_af), 32'd0);
            if (i == 6) chk("lit_a_af_at7", 32'(a_af), 32'd1);
            if (i == 6) chk("lit_a_full_at7", 32'(a_full), 32'd0);
        end
        chk("lit_a_full", 32'(a_full), 32'd1);
        chk("lit_a_cnt8", 32'(a_cnt), 32'd8);

        step_a(1, 8'hFF, 0, 0, 0);
        chk("lit_a_ov", 32'(a_ov), 32'd1);
        chk("lit_a_cnt8_ov", 32'(a_cnt), 32'd8);

        step_a(0, 8'h00, 0, 1, 0);
        chk("lit_a_ov_clr", 32'(a_ov), 32'd0);
        step_a(1, 8'hEE, 0, 1, 0);
        chk("lit_a_ov_setwins", 32'(a_ov), 32'd1);
        step_a(0, 8'h00, 0, 1, 0);

        // Drain; overflow writes must not have reached memory
        for (int i = 0; i < 8; i++) begin
            step_a(0, 8'h00, 1, 0, 0);
            chk("lit_a_drain", 32'(a_dout), 32'h10 + 32'(i));
            if (i == 6) chk("lit_a_ae_at1", 32'(a_ae), 32'd1);
            if (i == 5) chk("lit_a_ae_at2", 32'(a_ae), 32'd0);
        end
        chk("lit_a_empty", 32'(a_empty), 32'd1);

        step_a(0, 8'h00, 1, 0, 0);
        chk("lit_a_uf", 32'(a_uf), 32'd1);
        chk("lit_a_hold", 32'(a_dout), 32'h17);
        step_a(0, 8'h00, 0, 1, 0);

        // Both requests at empty: only the write lands
        step_a(1, 8'h33, 1, 0, 0);
        chk("lit_a_both_empty", 32'(a_cnt), 32'd1);
        step_a(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) step_a(1, 8'(8'h34 + i), 0, 0, 0);

        // Sustained streaming across pointer wrap
        for (int i = 0; i < 20; i++) begin
            step_a(1, 8'(8'h40 + i), 1, 0, 0);
            if (i < 4) chk("lit_a_stream", 32'(a_dout), 32'h33 + 32'(i));
        end
        chk("lit_a_stream_cnt", 32'(a_cnt), 32'd4);
        chk("lit_a_stream_last", 32'(a_dout), 32'h4F);

        for (int i = 0; i < 4; i++) step_a(1, 8'(8'h60 + i), 0, 0, 0);
        step_a(1, 8'h99, 1, 0, 0);
        chk("lit_a_both_full", 32'(a_cnt), 32'd7);
        chk("lit_a_both_full_d", 32'(a_dout), 32'h50);
        step_a(0, 8'h00, 0, 1, 0);

        step_a(0, 8'h00, 1, 0, 0);
        step_a(0, 8'h00, 1, 0, 0);
        step_a(1, 8'h77, 1, 1, 1);
        chk("lit_a_rst_mid_cnt", 32'(a_cnt), 32'd0);
        chk("lit_a_rst_mid_dout", 32'(a_dout), 32'd0);
        step_a(1, 8'hA5, 0, 0, 0);
        step_a(0, 8'h00, 1, 0, 0);
        chk("lit_a_a5", 32'(a_dout), 32'hA5);

        // FWFT instance
        step_b(1, 32'hDEADBEEF, 0, 0, 0);
        chk("lit_b_fwft", b_dout, 32'hDEADBEEF);
        step_b(0, 32'h0, 0, 0, 0);
        chk("lit_b_fwft_hold", b_dout, 32'hDEADBEEF);
        for (int i = 1; i < 12; i++) begin
            step_b(1, 32'h1000_0000 + 32'(i), 0, 0, 0);
            if (i == 10) chk("lit_b_af_at11", 32'(b_af), 32'd0);
        end
        chk("lit_b_af_at12", 32'(b_af), 32'd1);
        chk("lit_b_cnt12", 32'(b_cnt), 32'd12);
        step_b(0, 32'h0, 1, 0, 0);
        chk("lit_b_next", b_dout, 32'h1000_0001);

        for (int i = 0; i < 1000; i++)
            step_b(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 15) == 0), 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
